// File: rtl/dma_priority_arbiter_if.sv
// rtl/dma_priority_arbiter_if.sv - DMA channel request/acknowledge and register-write bundle
interface dma_priority_arbiter_if #(
  parameter int NCH = 4
);
  logic [NCH-1:0] DREQ;
  logic           dreqSense;
  logic           dackSense;
  logic           rotatingPriority;
  logic           maskWrite;
  logic [NCH-1:0] maskData;
  logic           singleMaskWrite;
  logic [1:0]     singleMaskChan;
  logic           singleMaskBit;
  logic           softReqWrite;
  logic [1:0]     softReqChan;
  logic           softReqBit;
  logic [NCH-1:0] autoinit;
  logic           assertDACK;
  logic           transferDone;
  logic           intEOP;
  logic           reqPending;
  logic [1:0]     grantChan;
  logic [NCH-1:0] DACK;
  logic [NCH-1:0] maskReg;
  logic [NCH-1:0] reqReg;
  logic [1:0]     topPriority;

  // Pins, register writes and timing/control drive the arbiter.
  modport master (
    output DREQ, dreqSense, dackSense, rotatingPriority,
    output maskWrite, maskData, singleMaskWrite, singleMaskChan, singleMaskBit,
    output softReqWrite, softReqChan, softReqBit, autoinit,
    output assertDACK, transferDone, intEOP,
    input  reqPending, grantChan, DACK, maskReg, reqReg, topPriority
  );

  // The arbiter itself.
  modport slave (
    input  DREQ, dreqSense, dackSense, rotatingPriority,
    input  maskWrite, maskData, singleMaskWrite, singleMaskChan, singleMaskBit,
    input  softReqWrite, softReqChan, softReqBit, autoinit,
    input  assertDACK, transferDone, intEOP,
    output reqPending, grantChan, DACK, maskReg, reqReg, topPriority
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// rtl/dma_priority_arbiter.sv - four-channel DREQ priority arbiter with mask/request registers and DACK drive
module dma_priority_arbiter (
  input logic                   CLK,
  input logic                   RESET,
  dma_priority_arbiter_if.slave bus
);
  localparam int NCH = 4;

  typedef enum logic [1:0] {IDLE, PENDING, ACTIVE} state_t;

  state_t         state;
  logic           pend_q;
  logic [1:0]     grant_q;
  logic [1:0]     top_q;
  logic [NCH-1:0] active_q;
  logic [NCH-1:0] mask_q;
  logic [NCH-1:0] req_q;

  logic [NCH-1:0] eff;
  logic [NCH-1:0] mask_nxt;
  logic [NCH-1:0] req_nxt;
  logic [1:0]     winner;
  logic [1:0]     cand;
  logic           found;
  logic           tc_done;

  // Effective requests: sense-corrected pin requests gated by mask, plus software requests.
  always_comb begin
    eff = ((bus.DREQ ^ {NCH{bus.dreqSense}}) & ~mask_q) | req_q;
  end

  assign tc_done = (state == ACTIVE) && bus.transferDone;

  // Scan from topPriority upward (mod 4) and take the first requesting channel.
  always_comb begin
    winner = top_q;
    cand   = top_q;
    found  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      cand = top_q + 2'(k);
      if (!found && eff[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Mask next value: TC auto-mask, overridden by single-bit write, overridden by full write.
  always_comb begin
    mask_nxt = mask_q;
    if (tc_done && bus.intEOP && !bus.autoinit[grant_q]) begin
      mask_nxt[grant_q] = 1'b1;
    end
    if (bus.singleMaskWrite) begin
      mask_nxt[bus.singleMaskChan] = bus.singleMaskBit;
    end
    if (bus.maskWrite) begin
      mask_nxt = bus.maskData;
    end
  end

  // Software request next value: completion clears the serviced bit unless rewritten this cycle.
  always_comb begin
    req_nxt = req_q;
    if (tc_done) begin
      req_nxt[grant_q] = 1'b0;
    end
    if (bus.softReqWrite) begin
      req_nxt[bus.softReqChan] = bus.softReqBit;
    end
  end

  // Arbitration FSM with registered grant, pending flag, active vector and priority pointer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      pend_q   <= 1'b0;
      grant_q  <= 2'd0;
      top_q    <= 2'd0;
      active_q <= '0;
      mask_q   <= '1;
      req_q    <= '0;
    end else begin
      mask_q <= mask_nxt;
      req_q  <= req_nxt;
      if (!bus.rotatingPriority) begin
        top_q <= 2'd0;
      end else if (tc_done) begin
        top_q <= grant_q + 2'd1;
      end
      case (state)
        IDLE: begin
          if (found) begin
            grant_q <= winner;
            pend_q  <= 1'b1;
            state   <= PENDING;
          end
        end
        PENDING: begin
          if (bus.assertDACK) begin
            active_q <= NCH'(1) << grant_q;
            pend_q   <= 1'b0;
            state    <= ACTIVE;
          end else if (!eff[grant_q]) begin
            pend_q <= 1'b0;
            state  <= IDLE;
          end
        end
        ACTIVE: begin
          if (bus.transferDone) begin
            active_q <= '0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          pend_q   <= 1'b0;
          active_q <= '0;
        end
      endcase
    end
  end

  assign bus.reqPending  = pend_q;
  assign bus.grantChan   = grant_q;
  assign bus.topPriority = top_q;
  assign bus.maskReg     = mask_q;
  assign bus.reqReg      = req_q;
  assign bus.DACK        = bus.dackSense ? active_q : ~active_q;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb/tb_dma_priority_arbiter.sv - randomized and directed bench for dma_priority_arbiter against a behavioural model
module tb_dma_priority_arbiter;
  logic CLK;
  logic RESET;
  int   n_cmp;
  int   n_fail;
  bit   mon_on;

  dma_priority_arbiter_if #(.NCH(4)) bus();

  dma_priority_arbiter dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural model: 0 = idle, 1 = pending, 2 = active; m_act = serviced channel or -1.
  int       m_st    = 0;
  bit       m_pend  = 0;
  int       m_grant = 0;
  int       m_top   = 0;
  int       m_act   = -1;
  bit [3:0] m_mask  = 4'hf;
  bit [3:0] m_req   = 4'h0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic lit(string name, logic [31:0] act, logic [31:0] mdl, logic [31:0] exp);
    chk(name, act, exp);
    chk({name, "_model"}, mdl, exp);
  endtask

  function automatic bit [3:0] exp_dack();
    bit [3:0] v = 4'h0;
    if (m_act >= 0) v[m_act] = 1'b1;
    return bus.dackSense ? v : ~v;
  endfunction

  task automatic model_step();
    bit [3:0] e;
    bit [3:0] nm;
    bit [3:0] nr;
    bit       done;
    bit       automask;
    bit       got;
    if (RESET) begin
      m_st = 0; m_pend = 0; m_grant = 0; m_top = 0; m_act = -1;
      m_mask = 4'hf; m_req = 4'h0;
      return;
    end
    for (int i = 0; i < 4; i++)
      e[i] = ((bus.DREQ[i] != bus.dreqSense) && !m_mask[i]) || m_req[i];
    done = 0; automask = 0; got = 0;
    if (m_st == 0) begin
      for (int k = 0; k < 4; k++) begin
        if (!got && e[(m_top + k) % 4]) begin
          m_grant = (m_top + k) % 4;
          got = 1;
        end
      end
      if (got) begin m_pend = 1; m_st = 1; end
    end else if (m_st == 1) begin
      if (bus.assertDACK) begin
        m_act = m_grant; m_pend = 0; m_st = 2;
      end else if (!e[m_grant]) begin
        m_pend = 0; m_st = 0;
      end
    end else if (bus.transferDone) begin
      done = 1;
      automask = bus.intEOP && !bus.autoinit[m_grant];
      m_act = -1; m_st = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.maskWrite) nm[i] = bus.maskData[i];
      else if (bus.singleMaskWrite && bus.singleMaskChan == i) nm[i] = bus.singleMaskBit;
      else if (automask && m_grant == i) nm[i] = 1'b1;
      else nm[i] = m_mask[i];
      if (bus.softReqWrite && bus.softReqChan == i) nr[i] = bus.softReqBit;
      else if (done && m_grant == i) nr[i] = 1'b0;
      else nr[i] = m_req[i];
    end
    m_mask = nm;
    m_req  = nr;
    if (!bus.rotatingPriority) m_top = 0;
    else if (done) m_top = (m_grant + 1) % 4;
  endtask

  // Compare process: advance the model on each edge and check every output just after it.
  initial begin
    forever begin
      @(posedge CLK);
      model_step();
      #1;
      if (mon_on) begin
        chk("reqPending", bus.reqPending, m_pend);
        chk("grantChan", bus.grantChan, m_grant);
        chk("topPriority", bus.topPriority, m_top);
        chk("maskReg", bus.maskReg, m_mask);
        chk("reqReg", bus.reqReg, m_req);
        chk("DACK", bus.DACK, exp_dack());
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic clear_pulses();
    bus.maskWrite = 0; bus.singleMaskWrite = 0; bus.softReqWrite = 0;
    bus.assertDACK = 0; bus.transferDone = 0; bus.intEOP = 0;
  endtask

  task automatic wait_pending(string name);
    int n = 0;
    while (!bus.reqPending && n < 10) begin
      tick();
      n++;
    end
    chk(name, bus.reqPending, 1);
  endtask

  task automatic pulse_dack();
    bus.assertDACK = 1; tick(); bus.assertDACK = 0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; mon_on = 0;
    RESET = 1;
    bus.DREQ = 0; bus.dreqSense = 0; bus.dackSense = 0; bus.rotatingPriority = 0;
    bus.maskData = 0; bus.singleMaskChan = 0; bus.singleMaskBit = 0;
    bus.softReqChan = 0; bus.softReqBit = 0; bus.autoinit = 0;
    clear_pulses();
    tick(); tick();
    mon_on = 1;
    RESET = 0;
    lit("rst_dack", bus.DACK, exp_dack(), 4'hf);
    lit("rst_mask", bus.maskReg, m_mask, 4'hf);
    lit("rst_pend", bus.reqPending, m_pend, 0);
    lit("rst_req", bus.reqReg, m_req, 0);

    // Fixed priority, ch0 wins over ch2, active-low DACK.
    bus.maskWrite = 1; bus.maskData = 4'h0; tick(); clear_pulses();
    bus.DREQ = 4'b0101; tick();
    lit("t1_pend", bus.reqPending, m_pend, 1);
    lit("t1_grant", bus.grantChan, m_grant, 0);
    pulse_dack();
    lit("t1_dack", bus.DACK, exp_dack(), 4'b1110);
    bus.transferDone = 1; bus.DREQ = 0; tick(); clear_pulses();
    lit("t1_dack_off", bus.DACK, exp_dack(), 4'b1111);

    // Rotating priority with all channels requesting.
    bus.rotatingPriority = 1; bus.DREQ = 4'hf;
    for (int k = 0; k < 4; k++) begin
      wait_pending("t2_wait");
      lit($sformatf("t2_grant%0d", k), bus.grantChan, m_grant, k);
      pulse_dack();
      bus.transferDone = 1; tick(); clear_pulses();
      lit($sformatf("t2_top%0d", k), bus.topPriority, m_top, (k + 1) % 4);
    end
    bus.DREQ = 0; bus.rotatingPriority = 0; tick();
    lit("t2_top_fixed", bus.topPriority, m_top, 0);

    // Software request bypasses a full mask.
    bus.maskWrite = 1; bus.maskData = 4'hf;
    bus.softReqWrite = 1; bus.softReqChan = 2; bus.softReqBit = 1;
    tick(); clear_pulses();
    lit("t3_req", bus.reqReg, m_req, 4'b0100);
    wait_pending("t3_wait");
    lit("t3_grant", bus.grantChan, m_grant, 2);
    pulse_dack();
    bus.transferDone = 1; tick(); clear_pulses();
    lit("t3_req_clr", bus.reqReg, m_req, 4'b0000);

    // Request withdrawn while pending.
    bus.maskWrite = 1; bus.maskData = 4'h0; tick(); clear_pulses();
    bus.DREQ = 4'b0010; tick();
    lit("t4_grant", bus.grantChan, m_grant, 1);
    bus.DREQ = 0; tick();
    lit("t4_pend", bus.reqPending, m_pend, 0);
    lit("t4_dack", bus.DACK, exp_dack(), 4'hf);
    tick();
    lit("t4_idle", bus.reqPending, m_pend, 0);

    // Terminal-count auto-mask, autoinit suppression, full-write override.
    for (int r = 0; r < 3; r++) begin
      bus.autoinit = (r == 1) ? 4'b1000 : 4'b0000;
      bus.maskWrite = 1; bus.maskData = 4'h0; tick(); clear_pulses();
      bus.DREQ = 4'b1000; tick();
      lit("t5_grant", bus.grantChan, m_grant, 3);
      pulse_dack();
      bus.transferDone = 1; bus.intEOP = 1; bus.DREQ = 0;
      if (r == 2) begin bus.maskWrite = 1; bus.maskData = 4'h0; end
      tick(); clear_pulses();
      lit($sformatf("t5_mask%0d", r), bus.maskReg, m_mask, (r == 0) ? 4'b1000 : 4'b0000);
    end
    bus.autoinit = 0;

    // Reset during an active-high DACK transfer.
    bus.dackSense = 1; bus.DREQ = 4'b0100; tick();
    lit("t6_grant", bus.grantChan, m_grant, 2);
    pulse_dack();
    lit("t6_dack", bus.DACK, exp_dack(), 4'b0100);
    RESET = 1; tick();
    lit("t6_dack_rst", bus.DACK, exp_dack(), 4'b0000);
    lit("t6_pend_rst", bus.reqPending, m_pend, 0);
    lit("t6_mask_rst", bus.maskReg, m_mask, 4'hf);
    lit("t6_top_rst", bus.topPriority, m_top, 0);
    RESET = 0; bus.dackSense = 0; bus.DREQ = 0;

    // Randomized traffic checked by the compare process.
    for (int c = 0; c < 4000; c++) begin
      RESET = ($urandom_range(0, 299) == 0);
      bus.DREQ = 4'($urandom);
      if ($urandom_range(0, 49) == 0) bus.dreqSense = ~bus.dreqSense;
      if ($urandom_range(0, 49) == 0) bus.dackSense = ~bus.dackSense;
      if ($urandom_range(0, 39) == 0) bus.rotatingPriority = ~bus.rotatingPriority;
      bus.maskWrite = ($urandom_range(0, 9) == 0);
      bus.maskData = 4'($urandom) & 4'($urandom);
      bus.singleMaskWrite = ($urandom_range(0, 7) == 0);
      bus.singleMaskChan = 2'($urandom);
      bus.singleMaskBit = 1'($urandom);
      bus.softReqWrite = ($urandom_range(0, 9) == 0);
      bus.softReqChan = 2'($urandom);
      bus.softReqBit = 1'($urandom);
      if ($urandom_range(0, 19) == 0) bus.autoinit = 4'($urandom);
      bus.assertDACK = ($urandom_range(0, 2) == 0);
      bus.transferDone = ($urandom_range(0, 3) == 0);
      bus.intEOP = 1'($urandom);
      tick();
    end
    RESET = 0;
    clear_pulses();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
- Resolves the four DREQ channels of the DMA controller into a single granted channel.
- Hands the granted channel to timing and control, then drives DACK for that channel while the transfer runs.
- Owns the mask and software-request registers. Supports fixed and rotating priority and programmable DREQ/DACK sense.
- Sits between the bus-interface pins and the timing/control FSM. All state is in CLK domain.

Parameters:
NCH, 4, number of DMA channels (the select width is fixed at 2; only 4 is supported)

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous, active-high reset
DREQ  input  NCH  raw channel requests from pins
dreqSense  input  1  0 = DREQ active-high, 1 = DREQ active-low
dackSense  input  1  0 = DACK active-low, 1 = DACK active-high
rotatingPriority  input  1  0 = fixed priority (ch0 highest), 1 = rotating
maskWrite  input  1  load all mask bits from maskData
maskData  input  NCH  all-mask write data
singleMaskWrite  input  1  write one mask bit
singleMaskChan  input  2  channel for single mask write
singleMaskBit  input  1  value for single mask write
softReqWrite  input  1  write one software request bit
softReqChan  input  2  channel for software request write
softReqBit  input  1  value for software request write
autoinit  input  NCH  per-channel autoinitialize enable (from the mode registers)
assertDACK  input  1  timing/control is in the DACK phase (S1/S2)
transferDone  input  1  one-cycle pulse: transfer for the granted channel complete (S4)
intEOP  input  1  terminal count reached, qualified by transferDone
reqPending  output  1  a granted request awaits service (drives the TC request condition)
grantChan  output  2  granted channel, valid while reqPending or an active transfer
DACK  output  NCH  acknowledge pins, polarity per dackSense
maskReg  output  NCH  current mask register
reqReg  output  NCH  current software request register
topPriority  output  2  channel currently holding highest priority

Behaviour:
- All state updates on posedge CLK. RESET is synchronous, active-high, and has priority over every other input.
- Reset values:
  - state = IDLE, reqPending = 0, grantChan = 0, topPriority = 0.
  - maskReg = all 1s (all channels masked), reqReg = 0.
  - Internal active vector = 0, so DACK is all inactive: all 1s when dackSense = 0, all 0s when dackSense = 1.
- Effective request: eff[i] = ((DREQ[i] ^ dreqSense) & ~maskReg[i]) | reqReg[i]. Software requests ignore the mask.
- Priority order starts at topPriority and proceeds in ascending channel order, modulo 4.
- In fixed mode topPriority is held at 0. Priority is evaluated combinationally from eff and registered at grant.
- FSM states: IDLE, PENDING, ACTIVE.
  - IDLE: if any eff bit is set, register the winning channel into grantChan, set reqPending = 1, go to PENDING. Latency is one clock from DREQ sampled to reqPending.
  - PENDING: grantChan is frozen; no re-arbitration.
    - If assertDACK = 1: set active[grantChan], clear reqPending, go to ACTIVE. DACK asserts the cycle after assertDACK is sampled.
    - Else if eff[grantChan] = 0 (request withdrawn or masked): clear reqPending, return to IDLE. New arbitration starts the following cycle.
  - ACTIVE: hold DACK for grantChan. DREQ changes and mask writes do not drop DACK.
    - On transferDone: clear active, clear reqReg[grantChan], go to IDLE.
    - If intEOP = 1 and autoinit[grantChan] = 0, also set maskReg[grantChan].
    - If rotatingPriority = 1, set topPriority = (grantChan + 1) mod 4, so the serviced channel becomes lowest priority.
- Mask register update precedence (highest first): maskWrite, then singleMaskWrite, then the TC auto-mask. The highest write applies per bit; the TC auto-mask is lost only for a bit overwritten that cycle.
- Request register precedence: a softReqWrite to grantChan in the same cycle as transferDone wins over the auto-clear.
- Switching rotatingPriority from 1 to 0 forces topPriority = 0 on the next clock.
- Only one DACK bit is ever active. No DACK is active outside ACTIVE.
- RESET mid-transfer: DACK goes inactive and reqPending = 0 on the reset edge, and all masks are set.

Test Plan:
1. Reset, write maskData = 0000, raise DREQ = 0101 (dreqSense = 0) -> reqPending = 1 one clock later, grantChan = 0. Pulse assertDACK -> DACK = 1110 (active-low). Pulse transferDone -> DACK = 1111, state IDLE.
2. Rotating mode, DREQ = 1111 held, four back-to-back transfers -> grant order 0,1,2,3. topPriority reads 1,2,3,0 after each transferDone.
3. Software request ch2 with maskReg = 1111, DREQ = 0 -> grantChan = 2. After transferDone, reqReg = 0000.
4. Grant ch1 in PENDING, drop DREQ[1] before assertDACK -> reqPending = 0 next clock, DACK stays inactive, back in IDLE.
5. transferDone with intEOP = 1 on ch3, autoinit = 0000 -> maskReg[3] = 1. Repeat with autoinit[3] = 1 -> maskReg[3] stays 0. Same cycle maskWrite maskData = 0000 -> maskReg = 0000.
6. RESET asserted while ACTIVE on ch2 with dackSense = 1 -> DACK = 0000, reqPending = 0, maskReg = 1111, topPriority = 0 after the reset edge.
